hash_cmd_sequencer: RTL
=======================

# hash_cmd_sequencer

Command sequencer between the AXI-Lite front end (`axi_wrapper` and its channel FIFOs) and the hash-table core. It consumes register writes popped from the write FIFOs, assembles KEY/DATA/CMD into one hash-table request, drives the request/response handshake to the core, and returns register reads (including status and lookup results) to the AXI read-data path.

## Interface
Parameters:
- `KEY_WIDTH`, 2, key width; must be ≤ `DATA_WIDTH`.
- `DATA_WIDTH`, 32, value width and register word width; must be ≥ 4.
- `TIMEOUT_CYCLES`, 255, maximum wait for a core response; must be ≥ 1; counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_valid`  in  1  register write offered by the write FIFOs.
- `wr_addr`  in  2  word address: 0 KEY, 1 DATA, 2 CMD, 3 STATUS (read-only).
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `rd_valid`  in  1  register read request.
- `rd_addr`  in  2  read word address.
- `rd_ready`  out  1  read request accepted.
- `rdata_valid`  out  1  read data valid.
- `rdata`  out  DATA_WIDTH  read data.
- `rdata_ready`  in  1  downstream consumes read data.
- `req_valid`  out  1  request to the hash core.
- `req_ready`  in  1  hash core accepts the request.
- `req_op`  out  2  0 lookup, 1 insert, 2 delete.
- `req_key`  out  KEY_WIDTH  request key.
- `req_data`  out  DATA_WIDTH  insert value.
- `rsp_valid`  in  1  core response, single-cycle pulse.
- `rsp_hit`  in  1  key found (lookup/delete) or insert succeeded.
- `rsp_data`  in  DATA_WIDTH  lookup value.

## Operation
- Registers: KEY (`KEY_WIDTH` bits, low bits of `wr_data`), DATA, STATUS = {…0, done[3], error[2], hit[1], busy[0]}.
- FSM states: IDLE, ISSUE, WAIT_RSP. `busy` = state ≠ IDLE.
- `wr_ready` = (state == IDLE). Writes to addr 3 are accepted and discarded.
- IDLE: a CMD write with `wr_data[1:0]` in {0,1,2} latches the op, clears done/hit/error, and moves to ISSUE. Opcode 3 issues no request: sets error=1, done=1, hit=0, stays IDLE.
- ISSUE: `req_valid`=1 with `req_op`/`req_key`/`req_data` stable from registers. On `req_valid && req_ready`: clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP: on `rsp_valid`, set hit=`rsp_hit`, done=1, error=0, and go to IDLE. A lookup with hit=1 also loads DATA ← `rsp_data`.
- `rsp_valid` in IDLE or ISSUE is ignored.
- Reads: address 0 returns KEY zero-extended; 1 returns DATA; 2 returns the last op zero-extended; 3 returns STATUS. A read never alters state and is allowed in any FSM state.
- Read path is a single-entry output register. `rd_ready` = !`rdata_valid` || `rdata_ready`.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE; KEY, DATA, op and STATUS = 0; `req_valid`=0; `rdata_valid`=0; `rdata`=0; timeout counter 0. This applies from any state; an in-flight request is abandoned, and a later `rsp_valid` is ignored.
- Outputs after reset: `wr_ready`=1, `rd_ready`=1, `req_op`/`req_key`/`req_data`=0.
- A CMD write accepted in cycle t gives `req_valid`=1 from t+1. The request handshake in cycle u gives WAIT_RSP from u+1. `rsp_valid` in cycle v gives IDLE with done=1 from v+1.
- A read accepted in cycle t has `rdata_valid`=1 from t+1, holding `rdata` until `rdata_ready`. Back-to-back reads sustain one per cycle.
- A read in the same cycle as a register update returns the pre-update value.
- `req_valid` never drops before `req_ready` is seen.

## Configuration
- `HASH_SEQ_TIMEOUT_EN` defined: the counter increments each WAIT_RSP cycle. When it reaches `TIMEOUT_CYCLES` without `rsp_valid`, set error=1, hit=0, done=1, and go to IDLE. `rsp_valid` in that same cycle takes priority as a normal response.
- Macro undefined: no counter; WAIT_RSP waits indefinitely, and the error bit is set only by opcode 3.

## Test plan
- Insert: write KEY=2'b10, DATA=32'hDEADBEEF, CMD=1; `req_ready`=1, `rsp_valid`/`rsp_hit`=1 two cycles later -> `req_op`=1, `req_key`=2, `req_data`=32'hDEADBEEF; STATUS=4'b1010.
- Lookup hit: CMD=0, response `rsp_hit`=1, `rsp_data`=32'h12345678 -> read of addr 1 returns 32'h12345678; writes while busy see `wr_ready`=0.
- Backpressure: hold `req_ready`=0 for 5 cycles -> `req_valid` and payload stable throughout; STATUS.busy=1. Read with `rdata_ready`=0 -> `rdata` held.
- Bad opcode: CMD=3 -> no `req_valid`; STATUS=4'b1100; next CMD=2 clears error.
- Timeout (`HASH_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): no `rsp_valid` -> IDLE exactly 4 cycles after entering WAIT_RSP; STATUS=4'b1100. Same run without the macro stays busy for 100 cycles.
- Reset mid-op: assert `reset`=0 in WAIT_RSP -> all registers 0, `req_valid`=0; a late `rsp_valid` leaves STATUS=0.

Source files
------------

// File: rtl/hash_cmd_sequencer.sv
// Turns KEY/DATA/CMD register writes into one hash-core request and serves register reads.
// Optional response timeout is enabled with `define HASH_SEQ_TIMEOUT_EN.
module hash_cmd_sequencer #(
  parameter int KEY_WIDTH      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [1:0]            rd_addr,
  output logic                  rd_ready,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rdata_ready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [1:0]            req_op,
  output logic [KEY_WIDTH-1:0]  req_key,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic                  rsp_valid,
  input  logic                  rsp_hit,
  input  logic [DATA_WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CMD    = 2'd2;
  localparam logic [1:0] OP_LOOKUP   = 2'd0;
  localparam logic [1:0] OP_INVALID  = 2'd3;

  // Illegal parameter sets leave this marker block in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 1 || KEY_WIDTH > DATA_WIDTH || DATA_WIDTH < 4) begin : g_bad_params
    localparam bit BAD_PARAMS = 1'b1;
  end

  state_t                  state;
  state_t                  state_next;
  logic [KEY_WIDTH-1:0]    key_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [1:0]              op_reg;
  logic                    done;
  logic                    error;
  logic                    hit;
  logic                    busy;
  logic                    cmd_go;
  logic                    cmd_bad;
  logic                    rsp_take;
  logic                    timed_out;
  logic                    rd_take;
  logic [DATA_WIDTH-1:0]   rd_mux;

`ifdef HASH_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  assign busy      = (state != IDLE);
  assign wr_ready  = (state == IDLE);
  assign req_valid = (state == ISSUE);
  assign req_op    = op_reg;
  assign req_key   = key_reg;
  assign req_data  = data_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_go     = 1'b0;
    cmd_bad    = 1'b0;
    rsp_take   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_valid && wr_addr == ADDR_CMD) begin
          if (wr_data[1:0] == OP_INVALID) begin
            cmd_bad = 1'b1;
          end else begin
            cmd_go     = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the final timeout cycle still counts as a normal response.
        if (rsp_valid) begin
          rsp_take   = 1'b1;
          state_next = IDLE;
        end
`ifdef HASH_SEQ_TIMEOUT_EN
        else if (tmo_cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_reg  <= '0;
      data_reg <= '0;
      op_reg   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      hit      <= 1'b0;
    end else begin
      if (state == IDLE && wr_valid) begin
        case (wr_addr)
          ADDR_KEY:  key_reg  <= wr_data[KEY_WIDTH-1:0];
          ADDR_DATA: data_reg <= wr_data;
          default:   ;
        endcase
      end
      if (cmd_go) begin
        op_reg <= wr_data[1:0];
        done   <= 1'b0;
        error  <= 1'b0;
        hit    <= 1'b0;
      end
      if (cmd_bad) begin
        done  <= 1'b1;
        error <= 1'b1;
        hit   <= 1'b0;
      end
      if (rsp_take) begin
        done  <= 1'b1;
        error <= 1'b0;
        hit   <= rsp_hit;
        if (op_reg == OP_LOOKUP && rsp_hit) begin
          data_reg <= rsp_data;
        end
      end
      if (timed_out) begin
        done  <= 1'b1;
        error <= 1'b1;
        hit   <= 1'b0;
      end
    end
  end

`ifdef HASH_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE && req_ready) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RSP) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

  // Single-entry read buffer; registers are sampled before any same-cycle update.
  assign rd_ready = !rdata_valid || rdata_ready;
  assign rd_take  = rd_valid && rd_ready;

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      2'd0:    rd_mux = DATA_WIDTH'(key_reg);
      2'd1:    rd_mux = data_reg;
      2'd2:    rd_mux = DATA_WIDTH'(op_reg);
      default: rd_mux = {{(DATA_WIDTH-4){1'b0}}, done, error, hit, busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else if (rd_take) begin
      rdata_valid <= 1'b1;
      rdata       <= rd_mux;
    end else if (rdata_ready) begin
      rdata_valid <= 1'b0;
    end
  end

endmodule
